// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined adder/subtractor. The lower half-word resolves in stage 1
// and the upper half-word in stage 2, so each stage holds one half-width carry-lookahead adder.
module cla_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] add_1,
    input  logic [WIDTH-1:0] add_2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int H = WIDTH / 2;

    // Parallel-prefix carry-lookahead add of two half-words; returns {carry, sum}.
    function automatic logic [H:0] cla_add(input logic [H-1:0] x,
                                           input logic [H-1:0] y,
                                           input logic         ci);
        logic [H-1:0] p;
        logic [H-1:0] gg;
        logic [H-1:0] pp;
        logic [H-1:0] c;
        p  = x ^ y;
        gg = x & y;
        pp = p;
        for (int d = 1; d < H; d = d * 2) begin
            for (int i = H - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        c[0] = ci;
        for (int i = 1; i < H; i++) begin
            c[i] = gg[i-1] | (pp[i-1] & ci);
        end
        return {gg[H-1] | (pp[H-1] & ci), p ^ c};
    endfunction

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             adv1;
    logic             adv2;
    logic             s1_valid;
    logic             s1_c;
    logic [H-1:0]     s1_lo;
    logic [H-1:0]     s1_a_hi;
    logic [H-1:0]     s1_b_hi;
    logic [H:0]       lo_res;
    logic [H:0]       hi_res;

    // Subtraction is A + ~B + ~borrow, so the operand and carry are inverted up front.
    assign b_eff  = sub ? ~add_2 : add_2;
    assign c_eff  = c_in ^ sub;
    assign lo_res = cla_add(add_1[H-1:0], b_eff[H-1:0], c_eff);
    assign hi_res = cla_add(s1_a_hi, s1_b_hi, s1_c);

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1 && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    sum   <= {hi_res[H-1:0], s1_lo};
                    c_out <= hi_res[H];
                    ovf   <= (s1_a_hi[H-1] == s1_b_hi[H-1]) && (hi_res[H-1] != s1_a_hi[H-1]);
                end
            end
        end
    end

    // Stage-1 payload carries no reset; s1_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (in_valid && adv1) begin
            s1_lo   <= lo_res[H-1:0];
            s1_c    <= lo_res[H];
            s1_a_hi <= add_1[WIDTH-1:H];
            s1_b_hi <= b_eff[WIDTH-1:H];
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: a 16-bit and an 8-bit instance share handshake controls
// and are checked against an arithmetic reference model through expected-result queues.
module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        c_in;
    logic        sub;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [7:0]  a8;
    logic [7:0]  b8;

    logic        in_ready16;
    logic        out_valid16;
    logic [15:0] sum16;
    logic        c_out16;
    logic        ovf16;
    logic        in_ready8;
    logic        out_valid8;
    logic [7:0]  sum8;
    logic        c_out8;
    logic        ovf8;

    int total = 0;
    int bad   = 0;

    // Expected results packed as {c_out, sum (zero-extended to 16), ovf}.
    logic [17:0] q16[$];
    logic [17:0] q8[$];

    typedef struct {
        bit          cons;
        bit          ov;
        bit          rdy;
        bit          exp_rdy;
        int          occ;
        logic [17:0] got16;
        logic [17:0] got8;
    } obs_t;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .add_1(a16), .add_2(b16), .c_in(c_in), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .c_out(c_out16), .ovf(ovf16)
    );

    cla_addsub_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .add_1(a8), .add_2(b8), .c_in(c_in), .sub(sub),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .c_out(c_out8), .ovf(ovf8)
    );

    // Plain integer arithmetic: unsigned result for sum/carry, signed result for overflow.
    function automatic logic [17:0] ref_model(int w, int a, int b, bit ci, bit s);
        int m;
        int res;
        int sa;
        int sb;
        int sres;
        bit c;
        bit o;
        m    = 1 << w;
        res  = s ? (a - b - int'(ci)) : (a + b + int'(ci));
        c    = s ? (res >= 0) : (res >= m);
        sa   = (a >= m / 2) ? a - m : a;
        sb   = (b >= m / 2) ? b - m : b;
        sres = s ? (sa - sb - int'(ci)) : (sa + sb + int'(ci));
        o    = (sres < -(m / 2)) || (sres >= m / 2);
        return {c, 16'(res & (m - 1)), o};
    endfunction

    function automatic logic [17:0] pop16();
        if (q16.size() == 0) return 'x;
        return q16.pop_front();
    endfunction

    function automatic logic [17:0] pop8();
        if (q8.size() == 0) return 'x;
        return q8.pop_front();
    endfunction

    task automatic applyStimulus(input bit v, input logic [15:0] a, input logic [15:0] b,
                                 input bit ci, input bit s);
        in_valid = v;
        a16      = a;
        b16      = b;
        c_in     = ci;
        sub      = s;
        a8       = 8'($urandom);
        b8       = 8'($urandom);
    endtask

    task automatic applyRandom(input bit v);
        applyStimulus(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // One clock: observe at negedge, record accepted beats in the model, then step past posedge.
    task automatic tick(output obs_t o);
        @(negedge clk);
        o.occ     = q16.size();
        o.exp_rdy = !rst && !(o.occ == 2 && !out_ready);
        o.rdy     = in_ready16;
        o.ov      = out_valid16;
        o.cons    = out_valid16 && out_ready && !rst;
        o.got16   = {c_out16, sum16, ovf16};
        o.got8    = {c_out8, 8'h00, sum8, ovf8};
        if (in_valid && o.exp_rdy) begin
            q16.push_back(ref_model(16, int'(a16), int'(b16), c_in, sub));
            q8.push_back(ref_model(8, int'(a8), int'(b8), c_in, sub));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q16.delete();
            q8.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (out_valid16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid16: got %b want 0", out_valid16); end
        total++; if (out_valid8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid8: got %b want 0", out_valid8); end
        total++; if (sum16 !== 16'h0000) begin bad++; $display("[TB] FAIL reset_sum: got %h want 0000", sum16); end
        total++; if (c_out16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_c_out: got %b want 0", c_out16); end
        total++; if (ovf16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", ovf16); end
        total++; if (in_ready16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready_during: got %b want 0", in_ready16); end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready16 !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready_after: got %b want 1", in_ready16); end
        total++; if (out_valid16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid_after: got %b want 0", out_valid16); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_sub();
        logic [15:0] va[8] = '{16'd432, 16'd432, 16'd65534, 16'h00FF, 16'd765, 16'd0, 16'h8000, 16'h7FFF};
        logic [15:0] vb[8] = '{16'd765, 16'd765, 16'd1, 16'h0001, 16'd432, 16'd1, 16'd1, 16'd1};
        bit          vc[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bit          vs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [17:0] ve[8] = '{{1'b0, 16'd1198, 1'b0}, {1'b0, 16'd1197, 1'b0},
                               {1'b1, 16'd0, 1'b0},    {1'b0, 16'h0100, 1'b0},
                               {1'b1, 16'd333, 1'b0},  {1'b0, 16'hFFFF, 1'b0},
                               {1'b1, 16'h7FFF, 1'b1}, {1'b0, 16'h8000, 1'b1}};
        obs_t        o;
        logic [17:0] e8;
        int          n = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t < 8) applyStimulus(1'b1, va[t], vb[t], vc[t], vs[t]);
            else       applyRandom(1'b0);
            tick(o);
            if (o.cons) begin
                total++; if (n > 7 || o.got16 !== ve[n]) begin bad++; $display("[TB] FAIL directed16 beat %0d: got %h want %h", n, o.got16, (n > 7) ? 18'h0 : ve[n]); end
                total++; if (t != n + 2) begin bad++; $display("[TB] FAIL directed_latency beat %0d: got cycle %0d want %0d", n, t, n + 2); end
                void'(pop16());
                e8 = pop8();
                total++; if (o.got8 !== e8) begin bad++; $display("[TB] FAIL directed8 beat %0d: got %h want %h", n, o.got8, e8); end
                n++;
            end
        end
        total++; if (n != 8) begin bad++; $display("[TB] FAIL directed_count: got %0d want 8", n); end
    endtask

    task automatic test_backpressure();
        obs_t        o;
        logic [17:0] e;
        logic [17:0] prev_got = '0;
        bit          prev_stall = 1'b0;
        int          sent = 0;
        int          recv = 0;
        applyRandom(1'b1);
        out_ready = 1'($urandom);
        for (int cyc = 0; cyc < 400 && recv < 10; cyc++) begin
            tick(o);
            if (in_valid && o.exp_rdy) sent++;
            total++; if (o.rdy !== o.exp_rdy) begin bad++; $display("[TB] FAIL bp_in_ready cyc %0d: got %b want %b", cyc, o.rdy, o.exp_rdy); end
            if (prev_stall) begin
                total++; if (o.ov !== 1'b1 || o.got16 !== prev_got) begin bad++; $display("[TB] FAIL bp_hold cyc %0d: got v=%b %h want v=1 %h", cyc, o.ov, o.got16, prev_got); end
            end
            if (o.cons) begin
                e = pop16();
                total++; if (o.got16 !== e) begin bad++; $display("[TB] FAIL bp_result beat %0d: got %h want %h", recv, o.got16, e); end
                void'(pop8());
                recv++;
            end
            prev_stall = o.ov && !out_ready;
            prev_got   = o.got16;
            applyRandom(sent < 10);
            out_ready = 1'($urandom);
        end
        total++; if (recv != 10) begin bad++; $display("[TB] FAIL bp_count: got %0d want 10", recv); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        obs_t        o;
        logic [17:0] e;
        int          got = 0;
        out_ready = 1'b0;
        applyRandom(1'b1);
        tick(o);
        tick(o);
        applyRandom(1'b0);
        rst = 1'b1;
        tick(o);
        total++; if (o.rdy !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_in_ready: got %b want 0", o.rdy); end
        rst       = 1'b0;
        out_ready = 1'b1;
        tick(o);
        total++; if (o.ov !== 1'b0) begin bad++; $display("[TB] FAIL mid_flush_out_valid: got %b want 0", o.ov); end
        applyRandom(1'b1);
        tick(o);
        applyRandom(1'b0);
        for (int j = 1; j <= 6; j++) begin
            tick(o);
            if (o.cons) begin
                got++;
                total++; if (j != 2) begin bad++; $display("[TB] FAIL mid_latency: got cycle %0d want 2", j); end
                e = pop16();
                total++; if (o.got16 !== e) begin bad++; $display("[TB] FAIL mid_result: got %h want %h", o.got16, e); end
                void'(pop8());
            end
        end
        total++; if (got != 1) begin bad++; $display("[TB] FAIL mid_count: got %0d want 1", got); end
    endtask

    task automatic test_random();
        obs_t        o;
        logic [17:0] e16;
        logic [17:0] e8;
        int          sent = 0;
        int          recv = 0;
        int          errs = 0;
        applyRandom(1'b1);
        out_ready = ($urandom_range(3) != 0);
        for (int cyc = 0; cyc < 60000 && recv < 10000; cyc++) begin
            tick(o);
            if (in_valid && o.exp_rdy) sent++;
            total++; if (o.rdy !== o.exp_rdy) begin bad++; errs++; if (errs < 10) $display("[TB] FAIL rnd_in_ready cyc %0d: got %b want %b", cyc, o.rdy, o.exp_rdy); end
            if (o.cons) begin
                e16 = pop16();
                e8  = pop8();
                total++; if (o.got16 !== e16) begin bad++; errs++; if (errs < 10) $display("[TB] FAIL rnd16 beat %0d: got %h want %h", recv, o.got16, e16); end
                total++; if (o.got8 !== e8) begin bad++; errs++; if (errs < 10) $display("[TB] FAIL rnd8 beat %0d: got %h want %h", recv, o.got8, e8); end
                recv++;
            end
            applyRandom((sent < 10000) && ($urandom_range(4) != 0));
            out_ready = ($urandom_range(3) != 0);
        end
        total++; if (recv != 10000) begin bad++; $display("[TB] FAIL rnd_count: got %0d want 10000", recv); end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        test_reset();
        test_add_sub();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
